// File: rtl/mem_access_ctrl_if.sv
// CPU-side memory request bundle for mem_access_ctrl.
// The CPU drives address/data/strobes; the controller returns data and a ready pulse.
interface mem_access_ctrl_if;
  logic [15:0] MAR;
  logic [15:0] MDR_out;
  logic        Mem_OE;
  logic        Mem_WE;
  logic [15:0] Data_to_CPU;
  logic        Mem_Ready;

  modport master (
    output MAR, MDR_out, Mem_OE, Mem_WE,
    input  Data_to_CPU, Mem_Ready
  );

  modport slave (
    input  MAR, MDR_out, Mem_OE, Mem_WE,
    output Data_to_CPU, Mem_Ready
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// LC-3 memory access controller: timed SRAM cycles, I/O at IO_ADDR, Mem_Ready pulse.
// Define MEM_ACCESS_ERR_EN to add a sticky Mem_Err output flagging aborted accesses.
module mem_access_ctrl #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF,
  parameter int unsigned ADDR_W      = 20
) (
  input  logic              Clk,
  input  logic              Reset,
  mem_access_ctrl_if.slave  bus,
  input  logic [15:0]       Switches,
  output logic [15:0]       HEX_Data,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [15:0]       SRAM_DQ,
  output logic              SRAM_CE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N
`ifdef MEM_ACCESS_ERR_EN
  ,
  output logic              Mem_Err
`endif
);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, WR_SETUP, WR_PULSE, DONE, HOLD
  } state_t;

  localparam logic [3:0] W = 4'(WAIT_STATES);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       rdata_q, rdata_d;
  logic [15:0]       hex_q, hex_d;
  logic              wr_q, wr_d;
  logic              busy;
  logic              abort;
  logic              is_io;

  assign is_io = (bus.MAR == IO_ADDR);
  assign busy  = (state_q == RD_WAIT) || (state_q == WR_SETUP) ||
                 (state_q == WR_PULSE);
  assign abort = busy && bus.Mem_OE && bus.Mem_WE;

  // Next-state and datapath capture; an abort overrides any progress.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    hex_d   = hex_q;
    wr_d    = wr_q;
    unique case (state_q)
      IDLE: begin
        if (!bus.Mem_WE) begin
          addr_d = ADDR_W'(bus.MAR);
          if (is_io) begin
            hex_d   = bus.MDR_out;
            wr_d    = 1'b0;
            state_d = DONE;
          end else begin
            wdata_d = bus.MDR_out;
            wr_d    = 1'b1;
            state_d = WR_SETUP;
          end
        end else if (!bus.Mem_OE) begin
          addr_d = ADDR_W'(bus.MAR);
          wr_d   = 1'b0;
          if (is_io) begin
            rdata_d = Switches;
            state_d = DONE;
          end else begin
            cnt_d   = W;
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          rdata_d = SRAM_DQ;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_SETUP: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          cnt_d   = W;
          state_d = WR_PULSE;
        end
      end
      WR_PULSE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: state_d = HOLD;
      HOLD: begin
        if (bus.Mem_OE && bus.Mem_WE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 16'h0;
      rdata_q <= 16'h0;
      hex_q   <= 16'h0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      hex_q   <= hex_d;
      wr_q    <= wr_d;
    end
  end

`ifdef MEM_ACCESS_ERR_EN
  logic err_q, err_d;

  // Sticky abort flag, cleared only by reset.
  always_comb begin
    err_d = err_q | abort;
  end

  // Error flag register.
  always_ff @(posedge Clk) begin
    if (Reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign Mem_Err = err_q;
`endif

  assign bus.Mem_Ready   = (state_q == DONE);
  assign bus.Data_to_CPU = rdata_q;
  assign HEX_Data        = hex_q;
  assign SRAM_ADDR       = addr_q;
  assign SRAM_CE_N       = 1'b0;
  assign SRAM_UB_N       = 1'b0;
  assign SRAM_LB_N       = 1'b0;
  assign SRAM_OE_N       = (state_q != RD_WAIT);
  assign SRAM_WE_N       = (state_q != WR_PULSE);
  assign SRAM_DQ = ((state_q == WR_SETUP) || (state_q == WR_PULSE) ||
                    ((state_q == DONE) && wr_q)) ? wdata_q : 16'hzzzz;

endmodule
